// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: core port has priority, debug/loader port
// is guaranteed service after STARVE_LIMIT consecutive waiting cycles.
// Grants and memory strobes are combinational; read responses and range
// errors are returned one cycle after the grant.
module dmem_arbiter #(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // core port
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [DW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  input  logic [3:0]    core_mask_i,
  output logic          core_gnt_o,
  output logic          core_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  output logic          core_err_o,
  // debug / loader port
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [DW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  input  logic [3:0]    dbg_mask_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_err_o,
  // pipeline stall
  output logic          stall_o,
  // memory side
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    mem_mask_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int            CW        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);
  localparam logic [DW-1:0] MEM_BYTES = DW'(MEM_SIZE_IN_KB * 1024);

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    mask;
  } req_t;

  typedef enum logic [1:0] {IDLE, RESP_CORE, RESP_DBG} state_t;

  state_t        state_q;
  logic [CW-1:0] starve_q;
  logic          core_err_q, dbg_err_q;
  logic          dbg_win, gnt_any, in_range;
  req_t          sel;

  // Arbitration: debug wins only when core is idle or debug has starved.
  always_comb begin
    dbg_win    = dbg_req_i & (~core_req_i | (starve_q == LIMIT));
    core_gnt_o = ~rst_i & core_req_i & ~dbg_win;
    dbg_gnt_o  = ~rst_i & dbg_win;
    stall_o    = ~rst_i & core_req_i & ~core_gnt_o;
    gnt_any    = core_gnt_o | dbg_gnt_o;
    sel        = dbg_gnt_o ? req_t'{dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_mask_i}
                           : req_t'{core_we_i, core_addr_i, core_wdata_i, core_mask_i};
    in_range   = sel.addr < MEM_BYTES;
  end

  // Memory strobe: forward the granted request only when it hits memory;
  // everything is held at zero otherwise so no stray write can occur.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_mask_o  = '0;
    if (gnt_any && in_range) begin
      mem_en_o    = 1'b1;
      mem_we_o    = sel.we;
      mem_addr_o  = sel.addr;
      mem_wdata_o = sel.wdata;
      mem_mask_o  = sel.mask;
    end
  end

  // Starve counter: counts cycles debug waits, cleared once it is served or gives up.
  always_ff @(posedge clk_i) begin
    if (rst_i)                         starve_q <= '0;
    else if (!dbg_req_i || dbg_gnt_o)  starve_q <= '0;
    else if (starve_q != LIMIT)        starve_q <= starve_q + CW'(1);
  end

  // Response FSM plus registered range-error flags, one cycle after grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      core_err_q <= 1'b0;
      dbg_err_q  <= 1'b0;
    end else begin
      if (core_gnt_o && !core_we_i && in_range)     state_q <= RESP_CORE;
      else if (dbg_gnt_o && !dbg_we_i && in_range)  state_q <= RESP_DBG;
      else                                          state_q <= IDLE;
      core_err_q <= core_gnt_o & ~in_range;
      dbg_err_q  <= dbg_gnt_o & ~in_range;
    end
  end

  // Response delivery; gated by reset so a pending read is dropped immediately.
  always_comb begin
    core_rvalid_o = ~rst_i & (state_q == RESP_CORE);
    dbg_rvalid_o  = ~rst_i & (state_q == RESP_DBG);
    core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    dbg_rdata_o   = dbg_rvalid_o  ? mem_rdata_i : '0;
    core_err_o    = ~rst_i & core_err_q;
    dbg_err_o     = ~rst_i & dbg_err_q;
  end

endmodule
